// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer:
// FSM state encoding, PC load-value select and the default interrupt vector.
package pc_seq_pkg;

  localparam int unsigned PC_W_DEFAULT      = 10;
  localparam int unsigned STK_DEPTH_DEFAULT = 8;
  localparam logic [PC_W_DEFAULT-1:0] VECTOR_DEFAULT = 10'h3FF;

  typedef enum logic [1:0] {
    INIT,
    FETCH,
    EXEC,
    INTR
  } seq_state_e;

  typedef enum logic [1:0] {
    SEL_IMM,
    SEL_STK,
    SEL_VEC
  } din_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/counter-facing bus of the PC sequencer. The optional stall input
// exists only when PC_SEQ_STALL_EN is defined.
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int unsigned N = PC_W_DEFAULT
);
  logic [N-1:0] pc_count;
  logic [N-1:0] imm_addr;
  logic         br_taken;
  logic         call;
  logic         ret;
  logic         reti;
  logic         sei;
  logic         cli;
  logic         int_req;
`ifdef PC_SEQ_STALL_EN
  logic         stall;
`endif
  logic         pc_ld;
  logic         pc_inc;
  logic [N-1:0] pc_din;
  logic         ir_ld;
  logic         int_en;
  logic         int_ack;
  logic         stk_err;

  modport master (
    output pc_count, imm_addr, br_taken, call, ret, reti, sei, cli, int_req,
`ifdef PC_SEQ_STALL_EN
    output stall,
`endif
    input  pc_ld, pc_inc, pc_din, ir_ld, int_en, int_ack, stk_err
  );

  modport slave (
    input  pc_count, imm_addr, br_taken, call, ret, reti, sei, cli, int_req,
`ifdef PC_SEQ_STALL_EN
    input  stall,
`endif
    output pc_ld, pc_inc, pc_din, ir_ld, int_en, int_ack, stk_err
  );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. Overflowing pushes are dropped, underflowing pops
// leave the pointer alone and read as zero; both raise a sticky error.
module ret_stack #(
  parameter int unsigned N         = 10,
  parameter int unsigned STK_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] push_data,
  output logic [N-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         err
);
  localparam int unsigned PW = $clog2(STK_DEPTH);

  logic [PW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [N-1:0]  mem [STK_DEPTH];
  logic [PW-1:0] wr_idx, rd_idx;

  assign wr_idx = cnt_q[PW-1:0];
  assign rd_idx = wr_idx - PW'(1);
  assign full   = (cnt_q == (PW+1)'(STK_DEPTH));
  assign empty  = (cnt_q == '0);
  assign top    = empty ? '0 : mem[rd_idx];
  assign err    = err_q;

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (push) begin
      if (full) err_d = 1'b1;
      else      cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop) begin
      if (empty) err_d = 1'b1;
      else       cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // NOTE: storage is not reset; entries above the pointer are never read.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute/interrupt sequencer driving the PC counter strobes.
// Optional STALL input enabled by defining PC_SEQ_STALL_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned  N         = PC_W_DEFAULT,
  parameter logic [N-1:0] VECTOR    = N'(VECTOR_DEFAULT),
  parameter int unsigned  STK_DEPTH = STK_DEPTH_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  seq_state_e   state_q, state_d;
  logic         int_en_q, int_en_d;
  logic         stall;
  logic         pc_ld, pc_inc, ir_ld, int_ack;
  logic         push, pop;
  din_sel_e     sel;
  logic [N-1:0] stk_top, din_mux;
  logic         stk_full, stk_empty, stk_err;

`ifdef PC_SEQ_STALL_EN
  assign stall = bus.stall;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    int_en_d = int_en_q;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    ir_ld    = 1'b0;
    int_ack  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    sel      = SEL_IMM;
    case (state_q)
      INIT:  state_d = FETCH;
      FETCH: begin
        ir_ld   = 1'b1;
        pc_inc  = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        if (bus.ret || bus.reti) begin
          pop   = 1'b1;
          pc_ld = 1'b1;
          sel   = SEL_STK;
        end else if (bus.call) begin
          push  = 1'b1;
          pc_ld = 1'b1;
        end else if (bus.br_taken) begin
          pc_ld = 1'b1;
        end
        if (bus.reti || bus.sei) int_en_d = 1'b1;
        if (bus.cli)             int_en_d = 1'b0;
        // Interrupt decision uses the enable as it stood before this EXEC.
        state_d = (bus.int_req && int_en_q) ? INTR : FETCH;
      end
      INTR: begin
        push     = 1'b1;
        pc_ld    = 1'b1;
        sel      = SEL_VEC;
        int_ack  = 1'b1;
        int_en_d = 1'b0;
        state_d  = FETCH;
      end
      default: state_d = INIT;
    endcase
    if (stall) begin
      state_d  = state_q;
      int_en_d = int_en_q;
      pc_ld    = 1'b0;
      pc_inc   = 1'b0;
      ir_ld    = 1'b0;
      int_ack  = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
    end
  end

  always_comb begin
    din_mux = bus.imm_addr;
    case (sel)
      SEL_STK: din_mux = stk_top;
      SEL_VEC: din_mux = VECTOR;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      int_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      int_en_q <= int_en_d;
    end
  end

  ret_stack #(
    .N         (N),
    .STK_DEPTH (STK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (bus.pc_count),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .err       (stk_err)
  );

  assign bus.pc_ld   = pc_ld;
  assign bus.pc_inc  = pc_inc;
  assign bus.pc_din  = pc_ld ? din_mux : '0;
  assign bus.ir_ld   = ir_ld;
  assign bus.int_en  = int_en_q;
  assign bus.int_ack = int_ack;
  assign bus.stk_err = stk_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic against a transaction-level model with its own PC counter and stack.
module tb_pc_sequencer;
  localparam int           N     = 10;
  localparam logic [N-1:0] VEC   = 10'h3FF;
  localparam int           DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.N(N)) bus ();

  pc_sequencer #(
    .N         (N),
    .VECTOR    (VEC),
    .STK_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic         pc_ld;
    logic         pc_inc;
    logic         ir_ld;
    logic         int_ack;
    logic         int_en;
    logic         stk_err;
    logic [N-1:0] pc_din;
  } outs_t;

  typedef enum {M_INIT, M_FETCH, M_EXEC, M_INTR} phase_e;

  phase_e       m_phase;
  bit           m_ie, m_err, stall_in;
  logic [N-1:0] m_stk[$];
  logic [N-1:0] m_pc;
  outs_t        exp_o, got;
  int           n_checks = 0;
  int           n_errors = 0;

  function automatic outs_t sample();
    return {bus.pc_ld, bus.pc_inc, bus.ir_ld, bus.int_ack, bus.int_en, bus.stk_err, bus.pc_din};
  endfunction

  function automatic void model_reset();
    m_phase = M_INIT;
    m_ie    = 1'b0;
    m_err   = 1'b0;
    m_stk.delete();
  endfunction

  // Expected outputs for the current cycle from the model and the driven inputs.
  function automatic void model_eval();
    exp_o        = '0;
    exp_o.int_en = m_ie;
    exp_o.stk_err = m_err;
    if (!stall_in) begin
      case (m_phase)
        M_FETCH: begin exp_o.pc_inc = 1'b1; exp_o.ir_ld = 1'b1; end
        M_EXEC: begin
          if (bus.ret || bus.reti) begin
            exp_o.pc_ld  = 1'b1;
            exp_o.pc_din = (m_stk.size() > 0) ? m_stk[$] : '0;
          end else if (bus.call || bus.br_taken) begin
            exp_o.pc_ld  = 1'b1;
            exp_o.pc_din = bus.imm_addr;
          end
        end
        M_INTR: begin exp_o.pc_ld = 1'b1; exp_o.pc_din = VEC; exp_o.int_ack = 1'b1; end
        default: ;
      endcase
    end
  endfunction

  function automatic void model_commit();
    if (stall_in) return;
    case (m_phase)
      M_INIT:  m_phase = M_FETCH;
      M_FETCH: m_phase = M_EXEC;
      M_EXEC: begin
        if (bus.ret || bus.reti) begin
          if (m_stk.size() > 0) void'(m_stk.pop_back());
          else m_err = 1'b1;
        end else if (bus.call) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(m_pc);
          else m_err = 1'b1;
        end
        m_phase = (bus.int_req && m_ie) ? M_INTR : M_FETCH;
        if (bus.reti || bus.sei) m_ie = 1'b1;
        if (bus.cli) m_ie = 1'b0;
      end
      M_INTR: begin
        if (m_stk.size() < DEPTH) m_stk.push_back(m_pc);
        else m_err = 1'b1;
        m_ie    = 1'b0;
        m_phase = M_FETCH;
      end
      default: ;
    endcase
    if (exp_o.pc_ld) m_pc = exp_o.pc_din;
    else if (exp_o.pc_inc) m_pc = m_pc + 1'b1;
  endfunction

  task automatic drive(input bit br, call, ret, reti, sei, cli, irq, input logic [N-1:0] imm);
    bus.br_taken = br;
    bus.call     = call;
    bus.ret      = ret;
    bus.reti     = reti;
    bus.sei      = sei;
    bus.cli      = cli;
    bus.int_req  = irq;
    bus.imm_addr = imm;
  endtask

  task automatic set_stall(input bit s);
    stall_in = s;
`ifdef PC_SEQ_STALL_EN
    bus.stall = s;
`endif
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, N'($urandom));
  endtask

  task automatic settle();
    bus.pc_count = m_pc;
    model_eval();
    @(negedge clk);
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_exec();
    int guard = 0;
    idle();
    while (m_phase != M_EXEC && guard < 8) begin
      settle();
      tick();
      guard++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    got = sample();
    n_checks++;
    if (got !== '0) begin n_errors++; $display("FAIL reset_init: got %p want all zero", got); end
    tick();
    settle();
    got = sample();
    n_checks++;
    if (got !== exp_o) begin n_errors++; $display("FAIL reset_fetch: got %p want %p", got, exp_o); end
    tick();
    // Pulse reset in the middle of an EXEC that is loading the PC.
    drive(1, 0, 0, 0, 1, 0, 0, 10'h155);
    settle();
    got = sample();
    n_checks++;
    if (got !== exp_o) begin n_errors++; $display("FAIL reset_exec: got %p want %p", got, exp_o); end
    #1 rst = 1'b1;
    model_reset();
    model_eval();
    #1 got = sample();
    n_checks++;
    if (got !== '0) begin n_errors++; $display("FAIL reset_mid_exec: got %p want all zero", got); end
    rst = 1'b0;
    idle();
    tick();
    settle();
    got = sample();
    n_checks++;
    if (got.pc_inc !== 1'b1 || got.ir_ld !== 1'b1 || got.int_en !== 1'b0 || got !== exp_o) begin
      n_errors++; $display("FAIL reset_refetch: got %p want %p", got, exp_o);
    end
    tick();
  endtask

  task automatic test_branch();
    goto_exec();
    drive(1, 0, 0, 0, 0, 0, 0, 10'h040);
    settle();
    got = sample();
    n_checks++;
    if (got.pc_ld !== 1'b1 || got.pc_din !== 10'h040 || got !== exp_o) begin
      n_errors++; $display("FAIL branch: got %p want ld=1 din=040", got);
    end
    tick();
    idle();
    settle();
    got = sample();
    n_checks++;
    if (got !== exp_o) begin n_errors++; $display("FAIL branch_fetch: got %p want %p", got, exp_o); end
    tick();
  endtask

  task automatic test_call_ret();
    goto_exec();
    m_pc = 10'h011;
    drive(0, 1, 0, 0, 0, 0, 0, 10'h100);
    settle();
    got = sample();
    n_checks++;
    if (got.pc_din !== 10'h100 || got !== exp_o) begin n_errors++; $display("FAIL call: got %p want %p", got, exp_o); end
    tick();
    goto_exec();
    drive(1, 1, 1, 0, 0, 0, 0, 10'h2AA);
    settle();
    got = sample();
    n_checks++;
    if (got.pc_ld !== 1'b1 || got.pc_din !== 10'h011) begin
      n_errors++; $display("FAIL ret: got %p want ld=1 din=011", got);
    end
    tick();
  endtask

  task automatic test_interrupt();
    goto_exec();
    drive(0, 0, 0, 0, 1, 0, 0, 10'h000);
    settle();
    tick();
    goto_exec();
    drive(0, 1, 0, 0, 0, 0, 1, 10'h080);
    settle();
    got = sample();
    n_checks++;
    if (got !== exp_o || got.int_en !== 1'b1) begin n_errors++; $display("FAIL int_call: got %p want %p", got, exp_o); end
    tick();
    idle();
    settle();
    got = sample();
    n_checks++;
    if (got.pc_din !== 10'h3FF || got.int_ack !== 1'b1 || got.pc_inc !== 1'b0 || got !== exp_o) begin
      n_errors++; $display("FAIL intr: got %p want %p", got, exp_o);
    end
    tick();
    settle();
    got = sample();
    n_checks++;
    if (got.int_en !== 1'b0 || got.int_ack !== 1'b0 || got !== exp_o) begin
      n_errors++; $display("FAIL intr_exit: got %p want %p", got, exp_o);
    end
    tick();
    drive(0, 0, 0, 1, 0, 0, 0, 10'h3C3);
    settle();
    got = sample();
    n_checks++;
    if (got.pc_din !== 10'h080 || got.pc_ld !== 1'b1) begin n_errors++; $display("FAIL reti: got %p want din=080", got); end
    tick();
    idle();
    settle();
    got = sample();
    n_checks++;
    if (got.int_en !== 1'b1 || got !== exp_o) begin n_errors++; $display("FAIL reti_ie: got %p want %p", got, exp_o); end
    tick();
  endtask

  task automatic test_stack_limits();
    logic [N-1:0] pushed[$];
    rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      goto_exec();
      m_pc = N'($urandom);
      if (i < DEPTH) pushed.push_back(m_pc);
      drive(0, 1, 0, 0, 0, 0, 0, N'($urandom));
      settle();
      got = sample();
      n_checks++;
      if (got.stk_err !== 1'b0 || got !== exp_o) begin n_errors++; $display("FAIL push_%0d: got %p want %p", i, got, exp_o); end
      tick();
    end
    goto_exec();
    for (int i = 0; i < 9; i++) begin
      goto_exec();
      drive(0, 0, 1, 0, 0, 0, 0, N'($urandom));
      settle();
      got = sample();
      n_checks++;
      if (got.stk_err !== 1'b1 || got.pc_din !== ((i < DEPTH) ? pushed[DEPTH-1-i] : 10'h000) || got !== exp_o) begin
        n_errors++; $display("FAIL pop_%0d: got %p want %p", i, got, exp_o);
      end
      tick();
    end
  endtask

`ifdef PC_SEQ_STALL_EN
  task automatic test_stall();
    goto_exec();
    idle();
    settle();
    tick();
    set_stall(1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      got = sample();
      n_checks++;
      if (got.pc_inc !== 1'b0 || got.ir_ld !== 1'b0 || got !== exp_o) begin
        n_errors++; $display("FAIL stall_%0d: got %p want %p", i, got, exp_o);
      end
      tick();
    end
    set_stall(1'b0);
    settle();
    got = sample();
    n_checks++;
    if (got.pc_inc !== 1'b1 || got.ir_ld !== 1'b1) begin n_errors++; $display("FAIL stall_release: got %p want fetch", got); end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0, N'($urandom));
`ifdef PC_SEQ_STALL_EN
      set_stall($urandom_range(0, 4) == 0);
`endif
      if ($urandom_range(0, 79) == 0) begin
        #1 rst = 1'b1;
        model_reset();
        model_eval();
        #1 got = sample();
        n_checks++;
        if (got !== '0) begin n_errors++; $display("FAIL rand_reset_%0d: got %p want all zero", i, got); end
        rst = 1'b0;
        @(negedge clk);
      end else begin
        settle();
        got = sample();
        n_checks++;
        if (got !== exp_o) begin n_errors++; $display("FAIL rand_%0d: got %p want %p", i, got, exp_o); end
      end
      tick();
    end
    set_stall(1'b0);
  endtask

  initial begin
    m_pc = '0;
    set_stall(1'b0);
    bus.pc_count = '0;
    test_reset();
    test_branch();
    test_call_ret();
    test_interrupt();
    test_stack_limits();
`ifdef PC_SEQ_STALL_EN
    test_stall();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
